// File: rtl/regfile_wb_sched.sv
// Writeback scheduler with register scoreboard.
// Purpose : arbitrates ALU/MEM writebacks onto one register-file write
//           port (round-robin) and tracks pending writes to detect
//           RAW/WAW hazards for the decode stage.
// Ports   : clk, rst (sync, active-high); done blocks grants and issue;
//           issue_* from decode, issue_stall back; alu_*/mem_* writeback
//           requests with combinational grants; we/rw/busw registered
//           write port; busy = scoreboard (bit n = write to xn pending).
module regfile_wb_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  logic        issue_valid,
    input  logic        issue_we,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    output logic        issue_stall,
    input  logic        alu_req,
    input  logic        mem_req,
    input  logic [4:0]  alu_rd,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] alu_data,
    input  logic [31:0] mem_data,
    output logic        alu_gnt,
    output logic        mem_gnt,
    output logic        we,
    output logic [4:0]  rw,
    output logic [31:0] busw,
    output logic [31:0] busy
);

    logic [31:0] busy_q;
    logic [31:0] busy_next;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        last_alu;
    logic        issue_accept;
    logic        gnt_any;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    // Bit 0 is never set, so x0 can never raise a hazard.
    assign busy = busy_q;

    assign issue_stall = issue_valid &
                         (done | busy_q[issue_rs1] | busy_q[issue_rs2] |
                          (issue_we & busy_q[issue_rd]));

    assign issue_accept = issue_valid & ~issue_stall;

    // last_alu=1 means ALU won the most recent grant, so MEM wins a tie.
    assign alu_gnt = ~done & alu_req & (~mem_req | ~last_alu);
    assign mem_gnt = ~done & mem_req & (~alu_req | last_alu);
    assign gnt_any = alu_gnt | mem_gnt;

    assign wb_rd   = alu_gnt ? alu_rd   : mem_rd;
    assign wb_data = alu_gnt ? alu_data : mem_data;

    // Clear applies before set so an issue to the register being written
    // this cycle keeps its busy bit.
    always_comb begin
        clr_mask = 32'h0;
        set_mask = 32'h0;
        if (we)
            clr_mask = 32'h1 << rw;
        if (issue_accept && issue_we)
            set_mask = 32'h1 << issue_rd;
        busy_next = ((busy_q & ~clr_mask) | set_mask) & ~32'h1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 32'h0;
            we       <= 1'b0;
            rw       <= 5'd0;
            busw     <= 32'h0;
            last_alu <= 1'b1;
        end else begin
            busy_q <= busy_next;
            we     <= gnt_any & (wb_rd != 5'd0);
            if (gnt_any) begin
                rw       <= wb_rd;
                busw     <= wb_data;
                last_alu <= alu_gnt;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched.
// Directed scenarios followed by random traffic against a reference model.
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        rst, done, issue_valid, issue_we;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_stall;
    logic        alu_req, mem_req;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_gnt, mem_gnt, we;
    logic [4:0]  rw;
    logic [31:0] busw, busy;

    always #5 clk = ~clk;

    regfile_wb_sched dut (
        .clk(clk), .rst(rst), .done(done),
        .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_stall(issue_stall),
        .alu_req(alu_req), .mem_req(mem_req),
        .alu_rd(alu_rd), .mem_rd(mem_rd),
        .alu_data(alu_data), .mem_data(mem_data),
        .alu_gnt(alu_gnt), .mem_gnt(mem_gnt),
        .we(we), .rw(rw), .busw(busw), .busy(busy)
    );

    // Staged stimulus, applied just after each falling edge.
    logic        s_rst, s_done, s_iv, s_iwe;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic        s_areq, s_mreq;
    logic [4:0]  s_ard, s_mrd;
    logic [31:0] s_adata, s_mdata;

    // Reference model state.
    bit      pend[32];     // register has an outstanding write
    int      winner_last;  // 0: MEM won last tie-relevant grant, 1: ALU
    bit      known;        // a reset has been applied
    int      writing_rd;   // register being written this cycle (0 = none)
    bit      a_granted, m_granted;

    typedef struct {
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;
    wb_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic idle_stage();
        s_rst = 0; s_done = 0; s_iv = 0; s_iwe = 0;
        s_rs1 = 0; s_rs2 = 0; s_rd = 0;
        s_areq = 0; s_mreq = 0; s_ard = 0; s_mrd = 0;
        s_adata = 0; s_mdata = 0;
    endtask

    task automatic cycle();
        bit          e_stall, ga, gm;
        logic [31:0] e_busy;
        logic [4:0]  g_rd;
        logic [31:0] g_data;
        wb_t         e;
        @(negedge clk);
        rst = s_rst; done = s_done;
        issue_valid = s_iv; issue_we = s_iwe;
        issue_rs1 = s_rs1; issue_rs2 = s_rs2; issue_rd = s_rd;
        alu_req = s_areq; mem_req = s_mreq;
        alu_rd = s_ard; mem_rd = s_mrd;
        alu_data = s_adata; mem_data = s_mdata;
        #2;
        e_stall = s_iv && (s_done || pend[s_rs1] || pend[s_rs2] ||
                           (s_iwe && pend[s_rd]));
        ga = 0; gm = 0;
        if (!s_done) begin
            if (s_areq && s_mreq) begin
                if (winner_last == 1) gm = 1;
                else ga = 1;
            end else begin
                ga = s_areq;
                gm = s_mreq;
            end
        end
        for (int i = 0; i < 32; i++) e_busy[i] = pend[i];
        if (known) begin
            chk("issue_stall", {31'b0, issue_stall}, {31'b0, e_stall});
            chk("alu_gnt", {31'b0, alu_gnt}, {31'b0, ga});
            chk("mem_gnt", {31'b0, mem_gnt}, {31'b0, gm});
            chk("busy", busy, e_busy);
        end
        g_rd   = ga ? s_ard : s_mrd;
        g_data = ga ? s_adata : s_mdata;
        if (s_rst) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
            winner_last = 1;
            known = 1;
            writing_rd = 0;
            e.we = 0; e.rd = 0; e.data = 0;
        end else begin
            if (writing_rd != 0) pend[writing_rd] = 0;
            if (s_iv && !e_stall && s_iwe && s_rd != 0) pend[s_rd] = 1;
            if (ga || gm) winner_last = ga ? 1 : 0;
            e.we = (ga || gm) && g_rd != 0;
            e.rd = g_rd;
            e.data = g_data;
            writing_rd = e.we ? int'(g_rd) : 0;
        end
        exp_q.push_back(e);
        a_granted = ga && !s_rst;
        m_granted = gm && !s_rst;
    endtask

    // Monitor: one expected write-port state per cycle, seen after the edge.
    always @(negedge clk) begin
        wb_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("we", {31'b0, we}, {31'b0, e.we});
            if (e.we) begin
                chk("rw", {27'b0, rw}, {27'b0, e.rd});
                chk("busw", busw, e.data);
            end
        end
    end

    initial begin
        winner_last = 1; known = 0; writing_rd = 0;
        a_granted = 0; m_granted = 0;
        idle_stage();
        s_rst = 1; cycle(); cycle();
        idle_stage(); cycle();

        // Issue rd=5, then dependent read of x5 stalls.
        s_iv = 1; s_iwe = 1; s_rs1 = 1; s_rs2 = 2; s_rd = 5; cycle();
        idle_stage(); s_iv = 1; s_rs1 = 5; cycle();
        idle_stage();
        // ALU writes x5; busy[5] clears two cycles later.
        s_areq = 1; s_ard = 5; s_adata = 32'h1234; cycle();
        idle_stage(); cycle(); cycle();
        s_iv = 1; s_rs1 = 5; cycle();

        // Tie after reset: mem, alu, mem, alu.
        idle_stage(); s_rst = 1; cycle();
        idle_stage();
        for (int i = 0; i < 4; i++) begin
            s_areq = 1; s_ard = 9; s_adata = 32'hA000_0000 + i;
            s_mreq = 1; s_mrd = 10; s_mdata = 32'hB000_0000 + i;
            cycle();
        end
        idle_stage(); cycle(); cycle();

        // Set wins over clear on the same register.
        s_areq = 1; s_ard = 7; s_adata = 32'h77; cycle();
        idle_stage(); s_iv = 1; s_iwe = 1; s_rd = 7; cycle();
        idle_stage(); cycle(); cycle();

        // Writes and issues to x0 leave no trace.
        s_mreq = 1; s_mrd = 0; s_mdata = 32'hDEAD; cycle();
        idle_stage(); s_iv = 1; s_iwe = 1; s_rd = 0; cycle();
        idle_stage(); cycle();

        // done blocks grants and issue.
        s_done = 1; s_areq = 1; s_ard = 4; s_adata = 32'h44;
        s_iv = 1; s_rd = 2; cycle();
        s_done = 0; s_iv = 0; cycle();
        idle_stage(); cycle();
        // Reset drops pending x3.
        s_iv = 1; s_iwe = 1; s_rd = 3; cycle();
        idle_stage(); s_rst = 1; s_areq = 1; s_ard = 6; s_adata = 32'h66;
        cycle();
        idle_stage(); cycle(); cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            s_rst  = ($urandom_range(0, 299) == 0);
            s_done = ($urandom_range(0, 24) == 0);
            if (!(s_areq && !a_granted)) begin
                s_areq  = $urandom_range(0, 1);
                s_ard   = 5'($urandom_range(0, 7));
                s_adata = $urandom;
            end
            if (!(s_mreq && !m_granted)) begin
                s_mreq  = $urandom_range(0, 1);
                s_mrd   = 5'($urandom_range(0, 7));
                s_mdata = $urandom;
            end
            s_iv  = ($urandom_range(0, 9) < 6);
            s_iwe = ($urandom_range(0, 9) < 7);
            s_rs1 = 5'($urandom_range(0, 7));
            s_rs2 = 5'($urandom_range(0, 7));
            s_rd  = 5'($urandom_range(0, 7));
            cycle();
        end
        idle_stage(); cycle(); cycle();
        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
